// File: rtl/mem_bus_arbiter_if.sv
// Burst memory bus between the cache arbiter and the AXI bridge.
// master: arbiter side (drives ar/aw/w); slave: bridge/memory side.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic [7:0]        aw_len;
   logic              w_valid;
   logic              w_ready;
   logic [DATA_W-1:0] w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic              w_last;
   logic              b_valid;

   modport master (
      output ar_valid, ar_addr, ar_len,
      input  ar_ready,
      input  r_valid, r_data, r_last,
      output aw_valid, aw_addr, aw_len,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid
   );

   modport slave (
      input  ar_valid, ar_addr, ar_len,
      output ar_ready,
      output r_valid, r_data, r_last,
      input  aw_valid, aw_addr, aw_len,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Merges NUM_RD cache read requesters and one write requester onto one
// burst bus. Ports: clk/rst, rd_* requesters, ret_* returns, wr_* writer,
// bus (master modport: ar/r/aw/w/b channels).
module mem_bus_arbiter #(
   parameter int NUM_RD = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINE_W = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD-1:0]        rd_req,
   input  logic [NUM_RD-1:0]        rd_line,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_rdy,
   output logic [NUM_RD-1:0]        ret_valid,
   output logic [LINE_W-1:0]        ret_data,
   input  logic                     wr_req,
   input  logic                     wr_line,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W/8-1:0]      wr_wstrb,
   input  logic [LINE_W-1:0]        wr_data,
   output logic                     wr_rdy,
   output logic                     wr_done,
   mem_bus_arbiter_if.master        bus
);

   localparam int BEATS = LINE_W / DATA_W;
   localparam int OFF   = $clog2(LINE_W / 8);
   localparam int BW    = $clog2(BEATS);
   localparam int SW    = DATA_W / 8;
   localparam int PW    = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam logic [7:0] LEN_LINE = 8'(BEATS - 1);
   localparam logic [BW-1:0] CNT_LAST = BW'(BEATS - 1);

   typedef enum logic [1:0] {
      R_IDLE, R_AR, R_DATA, R_RET
   } r_state_t;

   typedef enum logic [1:0] {
      W_IDLE, W_AW, W_DATA, W_B
   } w_state_t;

   function automatic logic [ADDR_W-1:0] align(
      input logic [ADDR_W-1:0] a
   );
      return {a[ADDR_W-1:OFF], {OFF{1'b0}}};
   endfunction

   function automatic logic same_line(
      input logic [ADDR_W-1:0] a,
      input logic [ADDR_W-1:0] b
   );
      return a[ADDR_W-1:OFF] == b[ADDR_W-1:OFF];
   endfunction

   // read side state
   r_state_t          r_state, r_next;
   logic [PW-1:0]     r_gnt;
   logic [PW-1:0]     rr_ptr;
   logic [ADDR_W-1:0] r_addr_q;
   logic              r_line_q;
   logic [BW-1:0]     r_cnt;
   logic [LINE_W-1:0] r_buf;
   logic [NUM_RD-1:0] rd_rdy_q;
   logic              ar_valid_q;
   logic              r_final;

   // write side state
   w_state_t          w_state, w_next;
   logic              wb_valid;
   logic              wb_line;
   logic [ADDR_W-1:0] wb_addr;
   logic [LINE_W-1:0] wb_data;
   logic [SW-1:0]     wb_strb;
   logic [BW-1:0]     w_cnt;
   logic              wr_rdy_q;
   logic              wr_done_q;
   logic              aw_valid_q;
   logic              w_final;

   // arbitration
   logic [NUM_RD-1:0] raw_blk;
   logic              gnt_found;
   logic [PW-1:0]     gnt_idx;
   logic [PW-1:0]     ptr_next;
   logic [ADDR_W-1:0] sel_addr;

   // A read to the line held in the write buffer waits for wr_done.
   // A write being accepted this very cycle counts as buffered too.
   always_comb begin
      raw_blk = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         raw_blk[i] =
            (wb_valid &&
             same_line(rd_addr[i*ADDR_W +: ADDR_W], wb_addr)) ||
            (w_state == W_IDLE && wr_req &&
             same_line(rd_addr[i*ADDR_W +: ADDR_W], wr_addr));
      end
   end

   // Scan upward from the RR pointer, wrapping at NUM_RD.
   always_comb begin
      int c;
      c         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         c = (int'(rr_ptr) + i) % NUM_RD;
         if (!gnt_found && rd_req[c] && !raw_blk[c]) begin
            gnt_found = 1'b1;
            gnt_idx   = PW'(c);
         end
      end
   end

   assign ptr_next = (gnt_idx == PW'(NUM_RD - 1)) ?
                     '0 : PW'(gnt_idx + 1'b1);
   assign sel_addr = rd_addr[gnt_idx*ADDR_W +: ADDR_W];
   assign r_final  = r_cnt == (r_line_q ? CNT_LAST : '0);

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE: if (gnt_found) r_next = R_AR;
         R_AR:   if (ar_valid_q && bus.ar_ready) r_next = R_DATA;
         R_DATA: if (bus.r_valid && r_final) r_next = R_RET;
         R_RET:  r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= R_IDLE;
         r_gnt      <= '0;
         rr_ptr     <= '0;
         r_addr_q   <= '0;
         r_line_q   <= 1'b0;
         r_cnt      <= '0;
         r_buf      <= '0;
         rd_rdy_q   <= '0;
         ar_valid_q <= 1'b0;
      end else begin
         r_state  <= r_next;
         rd_rdy_q <= '0;
         if (r_state == R_IDLE && gnt_found) begin
            rd_rdy_q <= NUM_RD'(1) << gnt_idx;
            r_gnt    <= gnt_idx;
            r_line_q <= rd_line[gnt_idx];
            r_addr_q <= rd_line[gnt_idx] ? align(sel_addr) : sel_addr;
            rr_ptr   <= ptr_next;
            r_cnt    <= '0;
            r_buf    <= '0;
         end
         // AR is driven from flops: valid rises once addr/len are latched
         // and drops on the handshake.
         if (r_state == R_AR)
            ar_valid_q <= ar_valid_q ? !bus.ar_ready : 1'b1;
         if (r_state == R_DATA && bus.r_valid) begin
            r_buf[r_cnt*DATA_W +: DATA_W] <= bus.r_data;
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   a_r_last: assert property (
      @(posedge clk) disable iff (rst)
      (r_state == R_DATA && bus.r_valid) |-> (bus.r_last == r_final)
   );

   assign rd_rdy       = rd_rdy_q;
   assign ret_valid    = (r_state == R_RET) ? (NUM_RD'(1) << r_gnt) : '0;
   assign ret_data     = r_buf;
   assign bus.ar_valid = ar_valid_q;
   assign bus.ar_addr  = r_addr_q;
   assign bus.ar_len   = r_line_q ? LEN_LINE : 8'd0;

   assign w_final = w_cnt == (wb_line ? CNT_LAST : '0);

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE: if (wr_req) w_next = W_AW;
         W_AW:   if (aw_valid_q && bus.aw_ready) w_next = W_DATA;
         W_DATA: if (bus.w_ready && w_final) w_next = W_B;
         W_B:    if (bus.b_valid) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state    <= W_IDLE;
         wb_valid   <= 1'b0;
         wb_line    <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         wb_strb    <= '0;
         w_cnt      <= '0;
         wr_rdy_q   <= 1'b0;
         wr_done_q  <= 1'b0;
         aw_valid_q <= 1'b0;
      end else begin
         w_state   <= w_next;
         wr_rdy_q  <= 1'b0;
         wr_done_q <= 1'b0;
         if (w_state == W_IDLE && wr_req) begin
            wr_rdy_q <= 1'b1;
            wb_valid <= 1'b1;
            wb_line  <= wr_line;
            wb_addr  <= wr_line ? align(wr_addr) : wr_addr;
            wb_data  <= wr_data;
            wb_strb  <= wr_line ? '1 : wr_wstrb;
            w_cnt    <= '0;
         end
         if (w_state == W_AW)
            aw_valid_q <= aw_valid_q ? !bus.aw_ready : 1'b1;
         if (w_state == W_DATA && bus.w_ready)
            w_cnt <= w_cnt + 1'b1;
         if (w_state == W_B && bus.b_valid) begin
            wr_done_q <= 1'b1;
            wb_valid  <= 1'b0;
         end
      end
   end

   assign wr_rdy       = wr_rdy_q;
   assign wr_done      = wr_done_q;
   assign bus.aw_valid = aw_valid_q;
   assign bus.aw_addr  = wb_addr;
   assign bus.aw_len   = wb_line ? LEN_LINE : 8'd0;
   assign bus.w_valid  = (w_state == W_DATA);
   assign bus.w_data   = bus.w_valid ?
                         wb_data[w_cnt*DATA_W +: DATA_W] : '0;
   assign bus.w_strb   = bus.w_valid ? wb_strb : '0;
   assign bus.w_last   = bus.w_valid && w_final;

endmodule
